lcd_rgb_rx: RTL and testbench
=============================

LCD_RGB_RX -- requirements
Module: lcd_rgb_rx

Interface
REQ-001 SHALL provide parameter HS_POL, default 0, active level of lcd_hs (0 = active-low).
REQ-002 SHALL provide parameter VS_POL, default 0, active level of lcd_vs (0 = active-low).
REQ-003 SHALL provide port lcd_pclk  input  1  pixel clock; every register is clocked on its rising edge.
REQ-004 SHALL provide port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL provide port lcd_de  input  1  data enable from the LCD-timing transmitter.
REQ-006 SHALL provide port lcd_hs  input  1  horizontal sync.
REQ-007 SHALL provide port lcd_vs  input  1  vertical sync.
REQ-008 SHALL provide port lcd_rgb  input  24  pixel data, R[23:16] G[15:8] B[7:0].
REQ-009 SHALL provide port pix_valid  output  1  captured pixel strobe.
REQ-010 SHALL provide port pix_data  output  24  captured pixel.
REQ-011 SHALL provide port pix_xpos  output  11  column of pix_data, 0-based.
REQ-012 SHALL provide port pix_ypos  output  11  row of pix_data, 0-based.
REQ-013 SHALL provide port frame_start  output  1  one-cycle pulse on each active-VS edge.
REQ-014 SHALL provide port h_disp  output  11  locked active width.
REQ-015 SHALL provide port v_disp  output  11  locked active height.
REQ-016 SHALL provide port locked  output  1  geometry stable.
REQ-017 SHALL provide port geom_err  output  1  sticky frame error flag.

Function
REQ-018 SHALL register lcd_de, lcd_hs, lcd_vs and lcd_rgb once (stage S1); all detection uses S1 values.
REQ-019 SHALL normalise syncs: vs_act = S1 vs XNOR VS_POL, and hs_act likewise with HS_POL.
REQ-020 SHALL define the frame edge as a vs_act 0->1 transition between consecutive S1 samples.
REQ-021 SHALL pulse frame_start for exactly one cycle, one cycle after the S1 sample that shows the edge (2 cycles after pin).
REQ-022 SHALL assert pix_valid 2 cycles after lcd_de is high at the pin, carrying that cycle's lcd_rgb, whenever state is not IDLE.
REQ-023 SHALL count pix_xpos from 0 per DE run, resetting on each DE 0->1.
REQ-024 SHALL increment pix_ypos on each DE 1->0 and zero it on the frame edge.
REQ-025 SHALL saturate pix_xpos and pix_ypos at 2047 and set geom_err on saturation.
REQ-026 SHALL latch the first DE run length of a frame as frame width W, and set geom_err if any later run in that frame differs from W.
REQ-027 SHALL take frame height H as the count of completed DE runs at the next frame edge.
REQ-028 SHALL implement states IDLE, SYNC and LOCK, with locked = (state == LOCK).
REQ-029 SHALL transition IDLE->SYNC on the first frame edge, discarding any partial frame.
REQ-030 SHALL transition SYNC->LOCK on a frame edge closing a frame with geom_err=0, W>0 and H>0, loading h_disp=W and v_disp=H.
REQ-031 SHALL stay in SYNC on a frame edge closing a bad frame.
REQ-032 SHALL transition LOCK->SYNC on a frame edge closing a frame with geom_err=1, W!=h_disp or H!=v_disp; h_disp and v_disp hold their old values.
REQ-033 SHALL stay in LOCK with h_disp and v_disp unchanged on a frame edge closing a matching frame.
REQ-034 SHALL clear geom_err on every frame edge after that frame is evaluated, so the flag covers one frame.
REQ-035 SHALL treat a frame edge while DE is high as an error (W/H not updated, geom_err evaluated set), and restart at x=0, y=0.
REQ-036 SHALL ignore hs_act for counting, using it only to set geom_err when it is active during DE.

Reset
REQ-037 SHALL, while rst=1 at a clock edge, force state IDLE and drive pix_valid=0, frame_start=0, pix_xpos=0, pix_ypos=0, pix_data=0, h_disp=0, v_disp=0, locked=0, geom_err=0, with S1 cleared to inactive levels.
REQ-038 SHALL treat reset mid-frame identically, requiring a fresh frame edge before pix_valid resumes.

Verification
REQ-039 SHALL be verified with 480x272 frames, HS_POL=VS_POL=0: frame 1 -> SYNC; after frame 2 edge -> locked=1, h_disp=480, v_disp=272.
REQ-040 SHALL be verified for pixel mapping: pixel at x=479,y=271 with rgb=24'h12ABEF -> pix_valid 2 cycles later with pix_xpos=479, pix_ypos=271, pix_data=24'h12ABEF.
REQ-041 SHALL be verified for a width glitch: one line of 479 in a locked frame -> geom_err=1 during that frame, locked=0 after its edge, h_disp stays 480.
REQ-042 SHALL be verified for a geometry change: switch to 800x480 -> LOCK->SYNC, then relock with h_disp=800, v_disp=480 one frame later.
REQ-043 SHALL be verified for reset mid-frame: rst at y=100 -> all outputs 0, no pix_valid until the next VS edge.
REQ-044 SHALL be verified for a VS edge with DE high: geom_err is set, no lock on that frame, and counters restart at 0.

Source files
------------

// File: rtl/lcd_rgb_rx.sv
// lcd_rgb_rx: captures DE-qualified RGB pixels, tracks x/y position and locks onto stable frame geometry
module lcd_rgb_rx #(
    parameter bit HS_POL = 1'b0,
    parameter bit VS_POL = 1'b0
) (
    input  logic        lcd_pclk,
    input  logic        rst,
    input  logic        lcd_de,
    input  logic        lcd_hs,
    input  logic        lcd_vs,
    input  logic [23:0] lcd_rgb,
    output logic        pix_valid,
    output logic [23:0] pix_data,
    output logic [10:0] pix_xpos,
    output logic [10:0] pix_ypos,
    output logic        frame_start,
    output logic [10:0] h_disp,
    output logic [10:0] v_disp,
    output logic        locked,
    output logic        geom_err
);
    typedef enum logic [1:0] {IDLE, SYNC, LOCK} state_t;

    state_t      st_q, st_d;
    logic        de_s1_q, hs_s1_q, vs_s1_q, de_s2_q, vsa_s2_q;
    logic [23:0] rgb_s1_q;
    logic        pix_valid_q, pix_valid_d, frame_start_q, geom_err_q, geom_err_d, w_set_q, w_set_d;
    logic [23:0] pix_data_q, pix_data_d;
    logic [10:0] pix_xpos_q, pix_xpos_d, pix_ypos_q, pix_ypos_d;
    logic [10:0] h_disp_q, h_disp_d, v_disp_q, v_disp_d, w_q, w_d;
    logic        hs_act, vs_act, fr_edge, de_rise, de_fall, x_max, y_max, x_sat, y_sat;
    logic        w_mis, w_set_eff, err_eff, good, match;
    logic [10:0] run_len, w_eff, h_eff;

    always_comb begin
        hs_act      = hs_s1_q ~^ HS_POL;
        vs_act      = vs_s1_q ~^ VS_POL;
        fr_edge     = vs_act & ~vsa_s2_q;
        de_rise     = de_s1_q & ~de_s2_q;
        de_fall     = ~de_s1_q & de_s2_q;
        x_max       = pix_xpos_q == 11'h7ff;
        y_max       = pix_ypos_q == 11'h7ff;
        x_sat       = de_s1_q & ~de_rise & ~fr_edge & x_max;
        y_sat       = de_fall & y_max;
        // pix_xpos_q still holds the last column of the run that just ended
        run_len     = x_max ? 11'h7ff : pix_xpos_q + 11'd1;
        w_mis       = de_fall & w_set_q & (run_len != w_q);
        w_eff       = (de_fall & ~w_set_q) ? run_len : w_q;
        w_set_eff   = w_set_q | de_fall;
        h_eff       = (de_fall & ~y_max) ? pix_ypos_q + 11'd1 : pix_ypos_q;
        err_eff     = geom_err_q | x_sat | y_sat | w_mis | (hs_act & de_s1_q) | (fr_edge & de_s1_q);
        good        = ~err_eff & w_set_eff & (w_eff != 11'd0) & (h_eff != 11'd0);
        match       = good & (w_eff == h_disp_q) & (h_eff == v_disp_q);
        pix_valid_d = de_s1_q & (st_q != IDLE);
        pix_data_d  = pix_valid_d ? rgb_s1_q : pix_data_q;
        pix_xpos_d  = !de_s1_q ? pix_xpos_q : (de_rise | fr_edge) ? 11'd0 : x_max ? pix_xpos_q : pix_xpos_q + 11'd1;
        pix_ypos_d  = fr_edge ? 11'd0 : h_eff;
        w_d         = fr_edge ? 11'd0 : w_eff;
        w_set_d     = ~fr_edge & w_set_eff;
        // a run straddling the frame edge is partial, so the new frame starts already flagged
        geom_err_d  = fr_edge ? de_s1_q : err_eff;
        st_d        = !fr_edge ? st_q : (st_q == IDLE) ? SYNC : ((st_q == SYNC) ? good : match) ? LOCK : SYNC;
        h_disp_d    = (fr_edge & (st_q == SYNC) & good) ? w_eff : h_disp_q;
        v_disp_d    = (fr_edge & (st_q == SYNC) & good) ? h_eff : v_disp_q;
    end

    always_ff @(posedge lcd_pclk) begin
        if (rst) begin
            de_s1_q       <= 1'b0;
            hs_s1_q       <= ~HS_POL;
            vs_s1_q       <= ~VS_POL;
            rgb_s1_q      <= '0;
            de_s2_q       <= 1'b0;
            vsa_s2_q      <= 1'b0;
            st_q          <= IDLE;
            pix_valid_q   <= 1'b0;
            pix_data_q    <= '0;
            pix_xpos_q    <= '0;
            pix_ypos_q    <= '0;
            frame_start_q <= 1'b0;
            h_disp_q      <= '0;
            v_disp_q      <= '0;
            geom_err_q    <= 1'b0;
            w_q           <= '0;
            w_set_q       <= 1'b0;
        end else begin
            de_s1_q       <= lcd_de;
            hs_s1_q       <= lcd_hs;
            vs_s1_q       <= lcd_vs;
            rgb_s1_q      <= lcd_rgb;
            de_s2_q       <= de_s1_q;
            vsa_s2_q      <= vs_act;
            st_q          <= st_d;
            pix_valid_q   <= pix_valid_d;
            pix_data_q    <= pix_data_d;
            pix_xpos_q    <= pix_xpos_d;
            pix_ypos_q    <= pix_ypos_d;
            frame_start_q <= fr_edge;
            h_disp_q      <= h_disp_d;
            v_disp_q      <= v_disp_d;
            geom_err_q    <= geom_err_d;
            w_q           <= w_d;
            w_set_q       <= w_set_d;
        end
    end

    assign pix_valid   = pix_valid_q;
    assign pix_data    = pix_data_q;
    assign pix_xpos    = pix_xpos_q;
    assign pix_ypos    = pix_ypos_q;
    assign frame_start = frame_start_q;
    assign h_disp      = h_disp_q;
    assign v_disp      = v_disp_q;
    assign locked      = st_q == LOCK;
    assign geom_err    = geom_err_q;
endmodule

// File: tb/tb_lcd_rgb_rx.sv
// tb_lcd_rgb_rx: directed checks of capture, lock, glitch, geometry change, saturation and reset
module tb_lcd_rgb_rx;
    logic        clk = 1'b0, rst = 1'b1, de = 1'b0, hs = 1'b1, vs = 1'b1;
    logic [23:0] rgb = '0;
    logic        pix_valid, frame_start, locked, geom_err;
    logic [23:0] pix_data;
    logic [10:0] pix_xpos, pix_ypos, h_disp, v_disp;
    int          checks = 0, errors = 0, nvalid = 0, n0;

    lcd_rgb_rx dut (
        .lcd_pclk(clk), .rst(rst), .lcd_de(de), .lcd_hs(hs), .lcd_vs(vs), .lcd_rgb(rgb),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_xpos(pix_xpos), .pix_ypos(pix_ypos),
        .frame_start(frame_start), .h_disp(h_disp), .v_disp(v_disp), .locked(locked), .geom_err(geom_err)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (pix_valid) nvalid++;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, 32'(pix_valid), 0);
        chk({tag, "_fs"}, 32'(frame_start), 0);
        chk({tag, "_x"}, 32'(pix_xpos), 0);
        chk({tag, "_y"}, 32'(pix_ypos), 0);
        chk({tag, "_data"}, 32'(pix_data), 0);
        chk({tag, "_hdisp"}, 32'(h_disp), 0);
        chk({tag, "_vdisp"}, 32'(v_disp), 0);
        chk({tag, "_locked"}, 32'(locked), 0);
        chk({tag, "_err"}, 32'(geom_err), 0);
    endtask

    task automatic line(input int w, input int hb, input logic [23:0] last_rgb);
        for (int i = 0; i < w; i++) begin
            de = 1'b1;
            rgb = (i == w - 1) ? last_rgb : 24'(i);
            tick();
        end
        for (int i = 0; i < hb; i++) begin
            de = 1'b0;
            hs = (i != 0);
            tick();
        end
        hs = 1'b1;
    endtask

    task automatic frame(input int w, input int h, input int glitch);
        for (int r = 0; r < h; r++) line((r == glitch) ? w - 1 : w, 4, 24'h0);
    endtask

    task automatic vsync;
        de = 1'b0;
        vs = 1'b0;
        tick();
        tick();
        chk("vs_fs_pulse", 32'(frame_start), 1);
        tick();
        chk("vs_fs_single", 32'(frame_start), 0);
        vs = 1'b1;
        repeat (3) tick();
    endtask

    initial begin
        repeat (3) tick();
        chk_zero("reset");
        rst = 1'b0;
        tick();
        line(8, 4, 24'h0);
        chk("idle_no_valid", 32'(nvalid), 0);
        vsync();
        chk("sync_unlocked", 32'(locked), 0);
        // widths are full size; heights are scaled down to keep the run short
        frame(480, 12, -1);
        vsync();
        chk("lock_locked", 32'(locked), 1);
        chk("lock_hdisp", 32'(h_disp), 480);
        chk("lock_vdisp", 32'(v_disp), 12);
        for (int r = 0; r < 12; r++) begin
            line((r == 5) ? 479 : 480, 4, 24'h0);
            if (r == 5) begin
                chk("glitch_err", 32'(geom_err), 1);
                chk("glitch_still_locked", 32'(locked), 1);
            end
        end
        vsync();
        chk("glitch_unlocked", 32'(locked), 0);
        chk("glitch_hdisp", 32'(h_disp), 480);
        chk("glitch_err_clr", 32'(geom_err), 0);
        frame(480, 12, -1);
        vsync();
        chk("relock", 32'(locked), 1);
        frame(800, 10, -1);
        vsync();
        chk("chg_unlocked", 32'(locked), 0);
        chk("chg_hdisp_hold", 32'(h_disp), 480);
        frame(800, 10, -1);
        vsync();
        chk("chg_relock", 32'(locked), 1);
        chk("chg_hdisp", 32'(h_disp), 800);
        chk("chg_vdisp", 32'(v_disp), 10);
        for (int r = 0; r < 271; r++) line(1, 1, 24'h0);
        line(480, 0, 24'h12ABEF);
        de = 1'b0;
        tick();
        chk("map_valid", 32'(pix_valid), 1);
        chk("map_x", 32'(pix_xpos), 479);
        chk("map_y", 32'(pix_ypos), 271);
        chk("map_data", 32'(pix_data), 32'h12ABEF);
        repeat (3) tick();
        chk("map_width_err", 32'(geom_err), 1);
        vsync();
        chk("map_unlocked", 32'(locked), 0);
        line(2050, 0, 24'h0);
        de = 1'b0;
        tick();
        chk("sat_valid", 32'(pix_valid), 1);
        chk("sat_x", 32'(pix_xpos), 2047);
        chk("sat_err", 32'(geom_err), 1);
        repeat (4) tick();
        vsync();
        for (int r = 0; r < 4; r++) line(8, 4, 24'h0);
        for (int i = 0; i < 8; i++) begin
            de = 1'b1;
            vs = (i < 4);
            rgb = 24'(i);
            tick();
            if (i == 5) begin
                chk("deedge_fs", 32'(frame_start), 1);
                chk("deedge_valid", 32'(pix_valid), 1);
                chk("deedge_x", 32'(pix_xpos), 0);
                chk("deedge_y", 32'(pix_ypos), 0);
                chk("deedge_err", 32'(geom_err), 1);
            end
        end
        de = 1'b0;
        tick();
        vs = 1'b1;
        repeat (3) tick();
        chk("deedge_nolock", 32'(locked), 0);
        vsync();
        for (int r = 0; r < 100; r++) line(2, 2, 24'h55AA55);
        chk("rst_pre_y", 32'(pix_ypos), 100);
        de = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk_zero("midrst");
        rst = 1'b0;
        n0 = nvalid;
        for (int r = 0; r < 5; r++) line(2, 2, 24'h0);
        chk("midrst_no_valid", 32'(nvalid), 32'(n0));
        vsync();
        line(2, 2, 24'h0);
        chk("midrst_resume", 32'(nvalid), 32'(n0 + 2));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
